// File: rtl/piso_pkg.sv
// Shared types and defaults for the PISO serializer slice.
// Frame length depends on the optional PISO_PARITY_EN build macro (see piso_serializer).
package piso_pkg;

    localparam int PISO_DEFAULT_WIDTH = 8;

    typedef enum logic {IDLE, SHIFT} piso_state_t;

    // Bits per frame: data word plus an optional trailing parity bit.
    function automatic int frame_len(input int width, input bit parity);
        return parity ? width + 1 : width;
    endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Word-input / serial-output bundle of the PISO serializer.
// master = word source and serial observer, slave = serializer.
interface piso_serializer_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;
    logic             SO;
    logic             SO_VALID;
    logic             DONE;
    logic             BUSY;

    modport master (
        output DIN, DIN_VALID,
        input  DIN_READY, SO, SO_VALID, DONE, BUSY
    );

    modport slave (
        input  DIN, DIN_VALID,
        output DIN_READY, SO, SO_VALID, DONE, BUSY
    );

endinterface

// File: rtl/piso_bit_counter.sv
// Frame bit counter: index of the bit currently on SO, 0..LAST.
// last flags the final frame bit, pre_last the one before it.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int LAST  = 7,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last,
    output logic pre_last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !last) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last     = (count == CNT_W'(LAST));
    assign pre_last = (count == CNT_W'(LAST - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter, MSB first, with a one-word holding register.
// Build macro PISO_PARITY_EN appends an even-parity bit to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input logic             C,
    input logic             CLR,
    piso_serializer_if.slave bus
);

`ifdef PISO_PARITY_EN
    localparam bit PARITY = 1'b1;
`else
    localparam bit PARITY = 1'b0;
`endif
    localparam int FRAME_W = frame_len(WIDTH, PARITY);
    localparam int LAST    = FRAME_W - 1;
    localparam int CNT_W   = $clog2(WIDTH + 1);

    // Parity rides in the shift register as the final bit, so it shifts out like data.
    function automatic logic [FRAME_W-1:0] frame_of(input logic [WIDTH-1:0] word);
`ifdef PISO_PARITY_EN
        return {word, ^word};
`else
        return word;
`endif
    endfunction

    piso_state_t        state;
    logic [FRAME_W-1:0] shreg;
    logic [WIDTH-1:0]   hold;
    logic               hold_full;
    logic               so;
    logic               so_valid;
    logic               done;

    logic accept;
    logic cnt_clr;
    logic cnt_inc;
    logic last;
    logic pre_last;

    assign accept = bus.DIN_VALID && !hold_full;

    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE:    cnt_clr = accept;
            SHIFT: begin
                cnt_clr = last;
                cnt_inc = !last;
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    piso_bit_counter #(
        .LAST  (LAST),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (C),
        .rst      (CLR),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .last     (last),
        .pre_last (pre_last)
    );

    // so is the register stage ahead of shreg: loading {frame, 0} puts the MSB on SO at once.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            shreg     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            so        <= 1'b0;
            so_valid  <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= SHIFT;
                        {so, shreg}  <= {frame_of(bus.DIN), 1'b0};
                        so_valid     <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (last) begin
                        done <= 1'b0;
                        if (hold_full) begin
                            {so, shreg} <= {frame_of(hold), 1'b0};
                            hold_full   <= 1'b0;
                        end else if (accept) begin
                            {so, shreg} <= {frame_of(bus.DIN), 1'b0};
                        end else begin
                            state    <= IDLE;
                            shreg    <= '0;
                            so       <= 1'b0;
                            so_valid <= 1'b0;
                        end
                    end else begin
                        {so, shreg} <= {shreg, 1'b0};
                        done        <= pre_last;
                        if (accept) begin
                            hold      <= bus.DIN;
                            hold_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    so       <= 1'b0;
                    so_valid <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DIN_READY = !hold_full;
    assign bus.SO        = so;
    assign bus.SO_VALID  = so_valid;
    assign bus.DONE      = done;
    assign bus.BUSY      = (state == SHIFT) || hold_full;

endmodule
